rsp_ahbic_dec_param: RTL and testbench

Parametrised bus-matrix input-stage decoder: maps each input-port address phase onto one of `NUM_PORTS` output stages using per-port base/mask regions, or onto an integrated default slave. It registers the data-phase owner to mux the response back to the input port. It extends the fixed three-port decoder with runtime region enables, a sticky idle-hold rule, and an error-capture status block for unmapped accesses. It sits between the input stage and the output stages of every generated AHB interconnect.

---
 rtl/rsp_ahbic_dec_param.sv | 167 ++++++++++++++++
 tb/tb_rsp_ahbic_dec_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rsp_ahbic_dec_param.sv
// AHB bus-matrix input-stage decoder: base/mask region decode onto NUM_PORTS output
// stages or an integrated default slave, data-phase response mux and unmapped-access capture.
module rsp_ahbic_dec_param #(
    parameter int unsigned                 NUM_PORTS   = 3,
    parameter int unsigned                 ADDR_LO     = 10,
    parameter logic [32*NUM_PORTS-1:0]     REGION_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [32*NUM_PORTS-1:0]     REGION_MASK = {3{32'hF000_0000}}
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HREADYS,
    input  logic                     sel_dec,
    input  logic [31-ADDR_LO:0]      decode_addr_dec,
    input  logic [1:0]               trans_dec,
    input  logic [NUM_PORTS-1:0]     region_en,
    input  logic [NUM_PORTS-1:0]     active_in,
    input  logic [NUM_PORTS-1:0]     readyout_in,
    input  logic [2*NUM_PORTS-1:0]   resp_in,
    input  logic [32*NUM_PORTS-1:0]  rdata_in,
    input  logic                     err_clr,
    output logic [NUM_PORTS-1:0]     sel_out,
    output logic                     active_dec,
    output logic                     HREADYOUTS,
    output logic [1:0]               HRESPS,
    output logic [31:0]              HRDATAS,
    output logic                     err_valid,
    output logic [15:0]              err_count,
    output logic [31-ADDR_LO:0]      err_addr
);

    localparam int unsigned PW  = $clog2(NUM_PORTS + 1);
    localparam logic [PW-1:0] DFT = PW'(NUM_PORTS);
    localparam logic [1:0] TRANS_IDLE = 2'b00;

    typedef enum logic [1:0] {DS_OKAY, DS_ERR1, DS_ERR2} ds_state_e;

    ds_state_e               ds_state_q;
    logic                    dft_ready_q;
    logic [1:0]              dft_resp_q;
    logic [PW-1:0]           data_port_q;
    logic [PW-1:0]           win_port;
    logic [PW-1:0]           addr_port;
    logic [31:0]             full_addr;
    logic                    sel_dft;
    logic                    dft_accept;
    logic [15:0]             err_count_q;
    logic                    err_valid_q;
    logic [31-ADDR_LO:0]     err_addr_q;

    assign full_addr = 32'(decode_addr_dec) << ADDR_LO;

    // Lowest enabled matching region wins; IDLE keeps the current data-phase owner.
    always_comb begin
        win_port = DFT;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (region_en[i] &&
                ((full_addr & REGION_MASK[32*i +: 32]) ==
                 (REGION_BASE[32*i +: 32] & REGION_MASK[32*i +: 32]))) begin
                win_port = PW'(i);
            end
        end
        if ((trans_dec == TRANS_IDLE) && (data_port_q != DFT)) begin
            addr_port = data_port_q;
        end else begin
            addr_port = win_port;
        end
    end

    always_comb begin
        sel_out    = '0;
        active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_out[i] = sel_dec && (addr_port == PW'(i));
            if (addr_port == PW'(i)) begin
                active_dec = active_in[i];
            end
        end
    end

    assign sel_dft    = sel_dec && (addr_port == DFT);
    assign dft_accept = sel_dft && HREADYS && trans_dec[1];

    // Response mux; the default slave returns zero read data.
    always_comb begin
        HREADYOUTS = dft_ready_q;
        HRESPS     = dft_resp_q;
        HRDATAS    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_port_q == PW'(i)) begin
                HREADYOUTS = readyout_in[i];
                HRESPS     = resp_in[2*i +: 2];
                HRDATAS    = rdata_in[32*i +: 32];
            end
        end
    end

    // Default slave: two-cycle ERROR response for accepted transfers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ds_state_q  <= DS_OKAY;
            dft_ready_q <= 1'b1;
            dft_resp_q  <= 2'b00;
        end else begin
            case (ds_state_q)
                DS_OKAY: begin
                    if (dft_accept) begin
                        ds_state_q  <= DS_ERR1;
                        dft_ready_q <= 1'b0;
                        dft_resp_q  <= 2'b01;
                    end
                end
                DS_ERR1: begin
                    ds_state_q  <= DS_ERR2;
                    dft_ready_q <= 1'b1;
                    dft_resp_q  <= 2'b01;
                end
                DS_ERR2: begin
                    if (dft_accept) begin
                        ds_state_q  <= DS_ERR1;
                        dft_ready_q <= 1'b0;
                        dft_resp_q  <= 2'b01;
                    end else begin
                        ds_state_q  <= DS_OKAY;
                        dft_ready_q <= 1'b1;
                        dft_resp_q  <= 2'b00;
                    end
                end
                default: begin
                    ds_state_q  <= DS_OKAY;
                    dft_ready_q <= 1'b1;
                    dft_resp_q  <= 2'b00;
                end
            endcase
        end
    end

    // Data-phase owner and unmapped-access status.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            data_port_q <= '0;
            err_count_q <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            if (HREADYS) begin
                data_port_q <= addr_port;
            end
            if (dft_accept) begin
                err_valid_q <= 1'b1;
                err_addr_q  <= decode_addr_dec;
                if (err_clr) begin
                    err_count_q <= 16'd1;
                end else if (err_count_q != 16'hFFFF) begin
                    err_count_q <= err_count_q + 16'd1;
                end
            end else if (err_clr) begin
                err_count_q <= '0;
                err_valid_q <= 1'b0;
            end
        end
    end

    assign err_count = err_count_q;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_rsp_ahbic_dec_param.sv
// Directed bench for rsp_ahbic_dec_param: 3-port default map, an overlapping map,
// and 1-port / 8-port builds sharing one address-phase stimulus.
module tb_rsp_ahbic_dec_param;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NS   = 2'b10;
    localparam logic [95:0]  B3  = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [95:0]  M3  = {3{32'hF000_0000}};
    localparam logic [95:0]  B3O = {32'h1000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [255:0] B8  = {32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
                                    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [255:0] M8  = {8{32'hF000_0000}};

    logic        clk = 1'b0;
    logic        rst, hready, sel, err_clr;
    logic [21:0] addr;
    logic [1:0]  trans;

    logic [2:0]  region_en3, active3, ready3;
    logic [5:0]  resp3;
    logic [95:0] rdata3;
    logic [7:0]  region_en8, active8, ready8;
    logic [15:0] resp8;
    logic [255:0] rdata8;
    logic [0:0]  region_en1, active1, ready1;
    logic [1:0]  resp1;
    logic [31:0] rdata1;

    logic [2:0]  sel3, selo;
    logic [7:0]  sel8;
    logic [0:0]  sel1;
    logic        act3, acto, act8, act1;
    logic        hro3, hroo, hro8, hro1;
    logic [1:0]  hresp3, hrespo, hresp8, hresp1;
    logic [31:0] hrdata3, hrdatao, hrdata8, hrdata1;
    logic        ev3, evo, ev8, ev1;
    logic [15:0] ec3, eco, ec8, ec1;
    logic [21:0] ea3, eao, ea8, ea1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rsp_ahbic_dec_param #(.NUM_PORTS(3), .ADDR_LO(10), .REGION_BASE(B3), .REGION_MASK(M3)) u3 (
        .HCLK(clk), .HRESET(rst), .HREADYS(hready), .sel_dec(sel), .decode_addr_dec(addr),
        .trans_dec(trans), .region_en(region_en3), .active_in(active3), .readyout_in(ready3),
        .resp_in(resp3), .rdata_in(rdata3), .err_clr(err_clr), .sel_out(sel3), .active_dec(act3),
        .HREADYOUTS(hro3), .HRESPS(hresp3), .HRDATAS(hrdata3), .err_valid(ev3), .err_count(ec3),
        .err_addr(ea3));

    rsp_ahbic_dec_param #(.NUM_PORTS(3), .ADDR_LO(10), .REGION_BASE(B3O), .REGION_MASK(M3)) u3o (
        .HCLK(clk), .HRESET(rst), .HREADYS(hready), .sel_dec(sel), .decode_addr_dec(addr),
        .trans_dec(trans), .region_en(region_en3), .active_in(active3), .readyout_in(ready3),
        .resp_in(resp3), .rdata_in(rdata3), .err_clr(err_clr), .sel_out(selo), .active_dec(acto),
        .HREADYOUTS(hroo), .HRESPS(hrespo), .HRDATAS(hrdatao), .err_valid(evo), .err_count(eco),
        .err_addr(eao));

    rsp_ahbic_dec_param #(.NUM_PORTS(8), .ADDR_LO(10), .REGION_BASE(B8), .REGION_MASK(M8)) u8 (
        .HCLK(clk), .HRESET(rst), .HREADYS(hready), .sel_dec(sel), .decode_addr_dec(addr),
        .trans_dec(trans), .region_en(region_en8), .active_in(active8), .readyout_in(ready8),
        .resp_in(resp8), .rdata_in(rdata8), .err_clr(err_clr), .sel_out(sel8), .active_dec(act8),
        .HREADYOUTS(hro8), .HRESPS(hresp8), .HRDATAS(hrdata8), .err_valid(ev8), .err_count(ec8),
        .err_addr(ea8));

    rsp_ahbic_dec_param #(.NUM_PORTS(1), .ADDR_LO(10), .REGION_BASE(32'h0000_0000),
                          .REGION_MASK(32'hF000_0000)) u1 (
        .HCLK(clk), .HRESET(rst), .HREADYS(hready), .sel_dec(sel), .decode_addr_dec(addr),
        .trans_dec(trans), .region_en(region_en1), .active_in(active1), .readyout_in(ready1),
        .resp_in(resp1), .rdata_in(rdata1), .err_clr(err_clr), .sel_out(sel1), .active_dec(act1),
        .HREADYOUTS(hro1), .HRESPS(hresp1), .HRDATAS(hrdata1), .err_valid(ev1), .err_count(ec1),
        .err_addr(ea1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        sel   = 1'b1;
        addr  = a[31:10];
        trans = t;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (ec3 !== 16'd0) begin errors++; $display("FAIL reset_count got %h exp %h", ec3, 16'd0); end
        checks++; if (ev3 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ev3); end
        checks++; if (ea3 !== 22'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", ea3); end
        checks++; if (hrdata3 !== 32'hAAAA_0000) begin errors++; $display("FAIL reset_rdata got %h exp AAAA0000", hrdata3); end
        checks++; if (hro3 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", hro3); end
        checks++; if (hresp3 !== 2'b00) begin errors++; $display("FAIL reset_resp got %b exp 00", hresp3); end
    endtask

    task automatic test_decode();
        logic [31:0] a_tab [3] = '{32'h0000_0400, 32'h1000_0000, 32'h2FFF_FC00};
        logic [2:0]  s_tab [3] = '{3'b001, 3'b010, 3'b100};
        logic        v_tab [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] d_tab [3] = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002};
        hready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(a_tab[i], NS);
            checks++; if (sel3 !== s_tab[i]) begin errors++; $display("FAIL decode_sel%0d got %b exp %b", i, sel3, s_tab[i]); end
            checks++; if (act3 !== v_tab[i]) begin errors++; $display("FAIL decode_active%0d got %b exp %b", i, act3, v_tab[i]); end
            tick();
            checks++; if (hrdata3 !== d_tab[i]) begin errors++; $display("FAIL decode_rdata%0d got %h exp %h", i, hrdata3, d_tab[i]); end
        end
    endtask

    task automatic test_unmapped();
        drive(32'h3000_0000, NS);
        checks++; if (sel3 !== 3'b000) begin errors++; $display("FAIL unmapped_sel got %b exp 000", sel3); end
        checks++; if (act3 !== 1'b1) begin errors++; $display("FAIL unmapped_active got %b exp 1", act3); end
        tick();
        checks++; if (hro3 !== 1'b0 || hresp3 !== 2'b01) begin errors++; $display("FAIL unmapped_err1 got %b/%b exp 0/01", hro3, hresp3); end
        checks++; if (ec3 !== 16'd1 || ev3 !== 1'b1) begin errors++; $display("FAIL unmapped_status got %0d/%b exp 1/1", ec3, ev3); end
        checks++; if (ea3 !== 22'h0C0000) begin errors++; $display("FAIL unmapped_addr got %h exp 0c0000", ea3); end
        hready = 1'b0;
        drive(32'h3000_0000, IDLE);
        tick();
        checks++; if (hro3 !== 1'b1 || hresp3 !== 2'b01) begin errors++; $display("FAIL unmapped_err2 got %b/%b exp 1/01", hro3, hresp3); end
        hready = 1'b1;
        tick();
        checks++; if (hro3 !== 1'b1 || hresp3 !== 2'b00 || hrdata3 !== 32'd0) begin
            errors++; $display("FAIL unmapped_idle_okay got %b/%b/%h exp 1/00/0", hro3, hresp3, hrdata3); end
    endtask

    task automatic test_back_to_back();
        hready = 1'b1;
        drive(32'h3000_0000, NS);
        tick();
        checks++; if (ec3 !== 16'd2) begin errors++; $display("FAIL b2b_count2 got %0d exp 2", ec3); end
        hready = 1'b0;
        tick();
        hready = 1'b1;
        drive(32'h3400_0000, NS);
        tick();
        checks++; if (hro3 !== 1'b0 || hresp3 !== 2'b01) begin errors++; $display("FAIL b2b_reerr1 got %b/%b exp 0/01", hro3, hresp3); end
        checks++; if (ec3 !== 16'd3 || ea3 !== 22'h0D0000) begin errors++; $display("FAIL b2b_count3 got %0d/%h exp 3/0d0000", ec3, ea3); end
        hready = 1'b0;
        tick();
        hready  = 1'b1;
        err_clr = 1'b1;
        drive(32'h3800_0000, NS);
        tick();
        checks++; if (ec3 !== 16'd1 || ev3 !== 1'b1 || ea3 !== 22'h0E0000) begin
            errors++; $display("FAIL b2b_clr_with_err got %0d/%b/%h exp 1/1/0e0000", ec3, ev3, ea3); end
        hready = 1'b0;
        drive(32'h3800_0000, IDLE);
        tick();
        err_clr = 1'b0;
        checks++; if (ec3 !== 16'd0 || ev3 !== 1'b0 || ea3 !== 22'h0E0000) begin
            errors++; $display("FAIL b2b_clr_alone got %0d/%b/%h exp 0/0/0e0000", ec3, ev3, ea3); end
        hready = 1'b1;
        tick();
    endtask

    task automatic test_region();
        hready = 1'b0;
        region_en3 = 3'b110;
        drive(32'h0000_1000, NS);
        checks++; if (sel3 !== 3'b000) begin errors++; $display("FAIL region_disabled got %b exp 000", sel3); end
        region_en3 = 3'b111;
        drive(32'h1000_0000, NS);
        checks++; if (selo !== 3'b010) begin errors++; $display("FAIL region_overlap got %b exp 010", selo); end
        region_en3 = 3'b101;
        #1;
        checks++; if (selo !== 3'b100) begin errors++; $display("FAIL region_overlap_p1off got %b exp 100", selo); end
        region_en3 = 3'b111;
        tick();
    endtask

    task automatic test_idle_hold();
        hready = 1'b1;
        drive(32'h2000_0000, NS);
        tick();
        drive(32'h0000_0400, IDLE);
        checks++; if (sel3 !== 3'b100) begin errors++; $display("FAIL idle_hold_sel got %b exp 100", sel3); end
        hready = 1'b0;
        drive(32'h1000_0000, NS);
        checks++; if (sel3 !== 3'b010) begin errors++; $display("FAIL stall_sel got %b exp 010", sel3); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (hrdata3 !== 32'hCCCC_0002) begin errors++; $display("FAIL stall_hold%0d got %h exp CCCC0002", i, hrdata3); end
        end
        hready = 1'b1;
        tick();
        checks++; if (hrdata3 !== 32'hBBBB_0001) begin errors++; $display("FAIL stall_release got %h exp BBBB0001", hrdata3); end
    endtask

    task automatic test_reset_mid();
        hready = 1'b1;
        drive(32'h3000_0000, NS);
        tick();
        checks++; if (hro3 !== 1'b0) begin errors++; $display("FAIL rstmid_pre_err1 got %b exp 0", hro3); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (hro3 !== 1'b1 || hresp3 !== 2'b00) begin errors++; $display("FAIL rstmid_fsm got %b/%b exp 1/00", hro3, hresp3); end
        checks++; if (ec3 !== 16'd0 || ev3 !== 1'b0 || ea3 !== 22'd0) begin
            errors++; $display("FAIL rstmid_status got %0d/%b/%h exp 0/0/0", ec3, ev3, ea3); end
        checks++; if (hrdata3 !== 32'hAAAA_0000) begin errors++; $display("FAIL rstmid_port got %h exp AAAA0000", hrdata3); end
    endtask

    task automatic test_sizes();
        hready = 1'b1;
        drive(32'h7000_0000, NS);
        checks++; if (sel8 !== 8'h80) begin errors++; $display("FAIL n8_sel7 got %h exp 80", sel8); end
        checks++; if (sel1 !== 1'b0) begin errors++; $display("FAIL n1_unmapped_sel got %b exp 0", sel1); end
        tick();
        checks++; if (hrdata8 !== 32'h8000_0007) begin errors++; $display("FAIL n8_rdata7 got %h exp 80000007", hrdata8); end
        checks++; if (hro1 !== 1'b0 || hresp1 !== 2'b01 || ec1 !== 16'd1) begin
            errors++; $display("FAIL n1_err got %b/%b/%0d exp 0/01/1", hro1, hresp1, ec1); end
        hready = 1'b0;
        drive(32'h0000_0400, NS);
        checks++; if (sel1 !== 1'b1 || sel8 !== 8'h01) begin errors++; $display("FAIL nx_sel0 got %b/%h exp 1/01", sel1, sel8); end
        tick();
        hready = 1'b1;
        tick();
        checks++; if (hrdata1 !== 32'h1111_1111 || hro1 !== 1'b1) begin errors++; $display("FAIL n1_port0 got %h/%b exp 11111111/1", hrdata1, hro1); end
        checks++; if (hrdata8 !== 32'h8000_0000) begin errors++; $display("FAIL n8_port0 got %h exp 80000000", hrdata8); end
        drive(32'h8000_0000, NS);
        checks++; if (sel8 !== 8'h00) begin errors++; $display("FAIL n8_unmapped got %h exp 00", sel8); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; hready = 1'b1; sel = 1'b0; err_clr = 1'b0; addr = '0; trans = IDLE;
        region_en3 = 3'b111; active3 = 3'b101; ready3 = 3'b111; resp3 = '0;
        rdata3 = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        region_en8 = 8'hFF; active8 = 8'hFF; ready8 = 8'hFF; resp8 = '0;
        for (int i = 0; i < 8; i++) rdata8[32*i +: 32] = 32'h8000_0000 | 32'(i);
        region_en1 = 1'b1; active1 = 1'b1; ready1 = 1'b1; resp1 = '0; rdata1 = 32'h1111_1111;
        test_reset();
        test_decode();
        test_unmapped();
        test_back_to_back();
        test_region();
        test_idle_hold();
        test_reset_mid();
        test_sizes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
